// File: rtl/mmc3_irq_counter_if.sv
// CPU/PPU-side signal bundle for the MMC3 scanline IRQ counter.
// The mapper drives the master side; the counter block is the slave.
interface mmc3_irq_counter_if;
    logic        ce;
    logic        enable;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        mw;
    logic        ppu_a12;
    logic        irq;
    logic [7:0]  counter;

    modport master (
        output ce, enable, addr, din, mw, ppu_a12,
        input  irq, counter
    );

    modport slave (
        input  ce, enable, addr, din, mw, ppu_a12,
        output irq, counter
    );
endinterface

// File: rtl/mmc3_irq_counter.sv
// MMC3 scanline IRQ: $C000-$FFFF register decode, filtered PPU A12
// edge counter and a registered level IRQ towards the CPU.
module mmc3_irq_counter #(
    parameter int FILTER_CYCLES = 3,
    parameter bit ALT_IRQ       = 1'b0
) (
    input logic               clk,
    input logic               reset,
    mmc3_irq_counter_if.slave bus
);
    localparam int LW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [LW-1:0] FMAX = LW'(FILTER_CYCLES);

    logic [7:0]    latch, latchN;
    logic [7:0]    counter, cntN;
    logic          reload, reloadN;
    logic          irqEn, irqEnN;
    logic          irqPend, pendN;
    logic          a12Q;
    logic [LW-1:0] lowCnt, lowN;
    logic          irqQ;

    logic       wr;
    logic [1:0] sel;
    logic       edgeEvt;
    logic [7:0] stepCnt;

    assign wr      = bus.ce & bus.mw & bus.enable & bus.addr[15] & bus.addr[14];
    assign sel     = {bus.addr[13], bus.addr[0]};
    assign edgeEvt = bus.ppu_a12 & ~a12Q & (lowCnt == FMAX);
    assign stepCnt = (counter == 8'd0 || reload) ? latch : counter - 8'd1;

    always_comb begin
        latchN  = latch;
        cntN    = counter;
        reloadN = reload;
        irqEnN  = irqEn;
        pendN   = irqPend;
        lowN    = lowCnt;

        if (bus.ppu_a12)
            lowN = '0;
        else if (bus.ce && lowCnt != FMAX)
            lowN = lowCnt + 1'b1;

        // A $C001 write on the same clk swallows the edge entirely.
        if (edgeEvt && !(wr && sel == 2'b01)) begin
            cntN    = stepCnt;
            reloadN = 1'b0;
            if (stepCnt == 8'd0 && irqEn &&
                (!ALT_IRQ || counter != 8'd0 || reload))
                pendN = 1'b1;
        end

        if (wr) begin
            case (sel)
                2'b00: latchN = bus.din;
                2'b01: begin
                    cntN    = 8'd0;
                    reloadN = 1'b1;
                end
                2'b10: begin
                    irqEnN = 1'b0;
                    pendN  = 1'b0;
                end
                default: irqEnN = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latch   <= 8'd0;
            counter <= 8'd0;
            reload  <= 1'b0;
            irqEn   <= 1'b0;
            irqPend <= 1'b0;
            lowCnt  <= '0;
            a12Q    <= 1'b0;
            irqQ    <= 1'b0;
        end else begin
            latch   <= latchN;
            counter <= cntN;
            reload  <= reloadN;
            irqEn   <= irqEnN;
            irqPend <= pendN;
            lowCnt  <= lowN;
            a12Q    <= bus.ppu_a12;
            irqQ    <= pendN & bus.enable;
        end
    end

    assign bus.irq     = irqQ;
    assign bus.counter = counter;
endmodule

// File: tb/tb_mmc3_irq_counter.sv
// Bench for mmc3_irq_counter: one DUT per ALT_IRQ setting, same stimulus,
// expectations queued per step and popped when the outputs are sampled.
module tb_mmc3_irq_counter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        ce = 1'b0;
    logic        enable = 1'b1;
    logic        mw = 1'b0;
    logic        a12 = 1'b1;
    logic [15:0] addr = 16'h0;
    logic [7:0]  din = 8'h0;

    mmc3_irq_counter_if bus0 ();
    mmc3_irq_counter_if bus1 ();

    assign bus0.ce = ce;
    assign bus0.enable = enable;
    assign bus0.addr = addr;
    assign bus0.din = din;
    assign bus0.mw = mw;
    assign bus0.ppu_a12 = a12;
    assign bus1.ce = ce;
    assign bus1.enable = enable;
    assign bus1.addr = addr;
    assign bus1.din = din;
    assign bus1.mw = mw;
    assign bus1.ppu_a12 = a12;

    mmc3_irq_counter #(.FILTER_CYCLES(3), .ALT_IRQ(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    mmc3_irq_counter #(.FILTER_CYCLES(3), .ALT_IRQ(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    typedef enum int {OP_WR, OP_WRDIS, OP_EDGE, OP_RST} op_e;
    typedef struct {
        op_e         op;
        logic [15:0] a;
        logic [7:0]  d;
        int          n;
        logic [7:0]  cnt;
        logic        i0;
        logic        i1;
    } vec_t;
    typedef struct {
        logic [7:0] cnt;
        logic       i0;
        logic       i1;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(op_e op, logic [15:0] a, logic [7:0] d, int n,
                       logic [7:0] cnt, logic i0, logic i1);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.n = n;
        v.cnt = cnt; v.i0 = i0; v.i1 = i1;
        vecs.push_back(v);
    endtask

    task automatic expect_(string name, logic [7:0] cnt, logic i0, logic i1);
        exp_t e;
        e.name = name; e.cnt = cnt; e.i0 = i0; e.i1 = i1;
        sb.push_back(e);
    endtask

    task automatic cmp(string name, string what, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s actual=%0h required=%0h", name, what, act, exp);
        end
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        cmp(e.name, "cnt0", bus0.counter, e.cnt);
        cmp(e.name, "cnt1", bus1.counter, e.cnt);
        cmp(e.name, "irq0", {7'd0, bus0.irq}, {7'd0, e.i0});
        cmp(e.name, "irq1", {7'd0, bus1.irq}, {7'd0, e.i1});
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(logic [15:0] a, logic [7:0] d, logic en);
        enable = en; ce = 1'b1; mw = 1'b1; addr = a; din = d;
        cyc();
        ce = 1'b0; mw = 1'b0; enable = 1'b1;
    endtask

    task automatic lowPhase(int n);
        a12 = 1'b0; ce = 1'b1;
        repeat (n) cyc();
        ce = 1'b0;
    endtask

    task automatic edgeA12(int n);
        lowPhase(n);
        a12 = 1'b1;
        cyc();
    endtask

    // A12 rises on the same clk as a CPU register write.
    task automatic edgeWr(int n, logic [15:0] a, logic [7:0] d);
        lowPhase(n);
        a12 = 1'b1; ce = 1'b1; mw = 1'b1; addr = a; din = d;
        cyc();
        ce = 1'b0; mw = 1'b0;
    endtask

    initial begin
        vec_t v;

        add(OP_WR,   16'hC000, 8'd3, 0, 8'd0, 0, 0);
        add(OP_WR,   16'hC001, 8'd0, 0, 8'd0, 0, 0);
        add(OP_WR,   16'hE001, 8'd0, 0, 8'd0, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd3, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd2, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 2, 8'd2, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd1, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd0, 1, 1);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd3, 1, 1);
        add(OP_WR,   16'hE000, 8'd0, 0, 8'd3, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd2, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd1, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd0, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd3, 0, 0);
        add(OP_WR,   16'hC000, 8'd0, 0, 8'd3, 0, 0);
        add(OP_WR,   16'hC001, 8'd0, 0, 8'd0, 0, 0);
        add(OP_WR,   16'hE001, 8'd0, 0, 8'd0, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd0, 1, 1);
        add(OP_WR,   16'hE000, 8'd0, 0, 8'd0, 0, 0);
        add(OP_WR,   16'hE001, 8'd0, 0, 8'd0, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd0, 1, 0);
        add(OP_WR,   16'hE000, 8'd0, 0, 8'd0, 0, 0);
        add(OP_WR,   16'hE001, 8'd0, 0, 8'd0, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd0, 1, 0);
        add(OP_WRDIS,16'hC000, 8'd5, 0, 8'd0, 0, 0);
        add(OP_WR,   16'hE000, 8'd0, 0, 8'd0, 0, 0);
        add(OP_WR,   16'hC001, 8'd0, 0, 8'd0, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd0, 0, 0);
        add(OP_WR,   16'hC000, 8'd5, 0, 8'd0, 0, 0);
        add(OP_WR,   16'hC001, 8'd0, 0, 8'd0, 0, 0);
        add(OP_WR,   16'hE001, 8'd0, 0, 8'd0, 0, 0);
        add(OP_EDGE, 16'h0,    8'd0, 3, 8'd5, 0, 0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_("reset", 8'd0, 1'b0, 1'b0);
        check();

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            expect_($sformatf("vec%0d", i), v.cnt, v.i0, v.i1);
            case (v.op)
                OP_WR:    wr(v.a, v.d, 1'b1);
                OP_WRDIS: wr(v.a, v.d, 1'b0);
                OP_EDGE:  edgeA12(v.n);
                default: begin
                    reset = 1'b1;
                    cyc();
                    reset = 1'b0;
                end
            endcase
            check();
        end

        expect_("c001_edge", 8'd0, 0, 0);
        edgeWr(3, 16'hC001, 8'd0);
        check();
        expect_("c001_after", 8'd5, 0, 0);
        edgeA12(3);
        check();

        expect_("lat1", 8'd5, 0, 0);
        wr(16'hC000, 8'd1, 1'b1);
        check();
        expect_("rel1", 8'd0, 0, 0);
        wr(16'hC001, 8'd0, 1'b1);
        check();
        expect_("load1", 8'd1, 0, 0);
        edgeA12(3);
        check();
        expect_("e000_edge", 8'd0, 0, 0);
        edgeWr(3, 16'hE000, 8'd0);
        check();
        expect_("reload_after_ack", 8'd1, 0, 0);
        edgeA12(3);
        check();
        expect_("e001_edge", 8'd0, 0, 0);
        edgeWr(3, 16'hE001, 8'd0);
        check();

        expect_("c000_edge", 8'd1, 0, 0);
        edgeWr(3, 16'hC000, 8'd7);
        check();
        expect_("hit0", 8'd0, 1, 1);
        edgeA12(3);
        check();
        expect_("newlatch", 8'd7, 1, 1);
        edgeA12(3);
        check();

        expect_("midreset", 8'd0, 0, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check();
        expect_("post_reset_edge", 8'd0, 0, 0);
        edgeA12(3);
        check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
